// File: rtl/xcfi_pkg.sv
// Shared types for the XCFI check trigger: FSM states, trace packet
// layout and default trigger depth.
package xcfi_pkg;

  localparam int XCFI_XLEN        = 32;
  localparam int XCFI_ILEN        = 32;
  localparam int XCFI_CHECK_DEPTH = 15;

  typedef enum logic [1:0] {
    COUNT,
    FIRE,
    DONE,
    HALT
  } trig_state_e;

  typedef struct packed {
    logic                   valid;
    logic [XCFI_ILEN-1:0]   insn;
    logic                   trap;
    logic                   halt;
    logic                   intr;
    logic [4:0]             rs1_addr;
    logic [4:0]             rs2_addr;
    logic [4:0]             rs3_addr;
    logic [XCFI_XLEN-1:0]   rs1_rdata;
    logic [XCFI_XLEN-1:0]   rs2_rdata;
    logic [XCFI_XLEN-1:0]   rs3_rdata;
    logic [4:0]             rd_addr;
    logic [XCFI_XLEN-1:0]   rd_wdata;
    logic [XCFI_XLEN-1:0]   pc_rdata;
    logic [XCFI_XLEN-1:0]   pc_wdata;
    logic [XCFI_XLEN-1:0]   mem_addr;
    logic [XCFI_XLEN/8-1:0] mem_rmask;
    logic [XCFI_XLEN/8-1:0] mem_wmask;
    logic [XCFI_XLEN-1:0]   mem_rdata;
    logic [XCFI_XLEN-1:0]   mem_wdata;
  } trace_t;

endpackage

// File: rtl/xcfi_trace_reg.sv
// One-stage pipeline register for the XCFI trace packet,
// asynchronously cleared to all-zero.
module xcfi_trace_reg
  import xcfi_pkg::*;
(
  input  logic   g_clk,
  input  logic   g_resetn,
  input  trace_t d,
  output trace_t q
);

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) q <= '0;
    else           q <= d;
  end

endmodule

// File: rtl/xcfi_check_trigger.sv
// Registers the XCFI trace and strobes `check` on the CHECK_DEPTH-th
// counted retirement. XCFI_TRIGGER_SKIP_TRAP_EN: trapping retirements do not count.
module xcfi_check_trigger
  import xcfi_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int ILEN        = 32,
  parameter int NRET        = 1,
  parameter int CHECK_DEPTH = XCFI_CHECK_DEPTH,
  parameter int CNT_W       = 5
) (
  input  logic                   g_clk,
  input  logic                   g_resetn,
  input  logic [NRET-1:0]        rvfi_valid,
  input  logic [NRET*ILEN-1:0]   rvfi_insn,
  input  logic [NRET-1:0]        rvfi_trap,
  input  logic [NRET-1:0]        rvfi_halt,
  input  logic [NRET-1:0]        rvfi_intr,
  input  logic [NRET*5-1:0]      rvfi_rs1_addr,
  input  logic [NRET*5-1:0]      rvfi_rs2_addr,
  input  logic [NRET*5-1:0]      rvfi_rs3_addr,
  input  logic [NRET*XLEN-1:0]   rvfi_rs1_rdata,
  input  logic [NRET*XLEN-1:0]   rvfi_rs2_rdata,
  input  logic [NRET*XLEN-1:0]   rvfi_rs3_rdata,
  input  logic [NRET*5-1:0]      rvfi_rd_addr,
  input  logic [NRET*XLEN-1:0]   rvfi_rd_wdata,
  input  logic [NRET*XLEN-1:0]   rvfi_pc_rdata,
  input  logic [NRET*XLEN-1:0]   rvfi_pc_wdata,
  input  logic [NRET*XLEN-1:0]   rvfi_mem_addr,
  input  logic [NRET*XLEN/8-1:0] rvfi_mem_rmask,
  input  logic [NRET*XLEN/8-1:0] rvfi_mem_wmask,
  input  logic [NRET*XLEN-1:0]   rvfi_mem_rdata,
  input  logic [NRET*XLEN-1:0]   rvfi_mem_wdata,
  output logic [NRET-1:0]        xc_rvfi_valid,
  output logic [NRET*ILEN-1:0]   xc_rvfi_insn,
  output logic [NRET-1:0]        xc_rvfi_trap,
  output logic [NRET-1:0]        xc_rvfi_halt,
  output logic [NRET-1:0]        xc_rvfi_intr,
  output logic [NRET*5-1:0]      xc_rvfi_rs1_addr,
  output logic [NRET*5-1:0]      xc_rvfi_rs2_addr,
  output logic [NRET*5-1:0]      xc_rvfi_rs3_addr,
  output logic [NRET*XLEN-1:0]   xc_rvfi_rs1_rdata,
  output logic [NRET*XLEN-1:0]   xc_rvfi_rs2_rdata,
  output logic [NRET*XLEN-1:0]   xc_rvfi_rs3_rdata,
  output logic [NRET*5-1:0]      xc_rvfi_rd_addr,
  output logic [NRET*XLEN-1:0]   xc_rvfi_rd_wdata,
  output logic [NRET*XLEN-1:0]   xc_rvfi_pc_rdata,
  output logic [NRET*XLEN-1:0]   xc_rvfi_pc_wdata,
  output logic [NRET*XLEN-1:0]   xc_rvfi_mem_addr,
  output logic [NRET*XLEN/8-1:0] xc_rvfi_mem_rmask,
  output logic [NRET*XLEN/8-1:0] xc_rvfi_mem_wmask,
  output logic [NRET*XLEN-1:0]   xc_rvfi_mem_rdata,
  output logic [NRET*XLEN-1:0]   xc_rvfi_mem_wdata,
  output logic                   check,
  output logic [CNT_W-1:0]       retire_count,
  output logic                   done,
  output logic                   halted_early
);

  if (NRET != 1) begin : g_bad_nret
    $error("xcfi_check_trigger: only NRET=1 is supported");
  end
  if (XLEN != XCFI_XLEN || ILEN != XCFI_ILEN) begin : g_bad_width
    $error("xcfi_check_trigger: XLEN/ILEN must match xcfi_pkg");
  end
  if (CHECK_DEPTH < 1 || CHECK_DEPTH > (1 << CNT_W) - 1) begin : g_bad_depth
    $error("xcfi_check_trigger: CHECK_DEPTH out of range for CNT_W");
  end

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHECK_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CHECK_DEPTH);

  trace_t trc_d;
  trace_t trc_q;

  assign trc_d.valid     = rvfi_valid;
  assign trc_d.insn      = rvfi_insn;
  assign trc_d.trap      = rvfi_trap;
  assign trc_d.halt      = rvfi_halt;
  assign trc_d.intr      = rvfi_intr;
  assign trc_d.rs1_addr  = rvfi_rs1_addr;
  assign trc_d.rs2_addr  = rvfi_rs2_addr;
  assign trc_d.rs3_addr  = rvfi_rs3_addr;
  assign trc_d.rs1_rdata = rvfi_rs1_rdata;
  assign trc_d.rs2_rdata = rvfi_rs2_rdata;
  assign trc_d.rs3_rdata = rvfi_rs3_rdata;
  assign trc_d.rd_addr   = rvfi_rd_addr;
  assign trc_d.rd_wdata  = rvfi_rd_wdata;
  assign trc_d.pc_rdata  = rvfi_pc_rdata;
  assign trc_d.pc_wdata  = rvfi_pc_wdata;
  assign trc_d.mem_addr  = rvfi_mem_addr;
  assign trc_d.mem_rmask = rvfi_mem_rmask;
  assign trc_d.mem_wmask = rvfi_mem_wmask;
  assign trc_d.mem_rdata = rvfi_mem_rdata;
  assign trc_d.mem_wdata = rvfi_mem_wdata;

  xcfi_trace_reg u_trace_reg (
    .g_clk    (g_clk),
    .g_resetn (g_resetn),
    .d        (trc_d),
    .q        (trc_q)
  );

  assign xc_rvfi_valid     = trc_q.valid;
  assign xc_rvfi_insn      = trc_q.insn;
  assign xc_rvfi_trap      = trc_q.trap;
  assign xc_rvfi_halt      = trc_q.halt;
  assign xc_rvfi_intr      = trc_q.intr;
  assign xc_rvfi_rs1_addr  = trc_q.rs1_addr;
  assign xc_rvfi_rs2_addr  = trc_q.rs2_addr;
  assign xc_rvfi_rs3_addr  = trc_q.rs3_addr;
  assign xc_rvfi_rs1_rdata = trc_q.rs1_rdata;
  assign xc_rvfi_rs2_rdata = trc_q.rs2_rdata;
  assign xc_rvfi_rs3_rdata = trc_q.rs3_rdata;
  assign xc_rvfi_rd_addr   = trc_q.rd_addr;
  assign xc_rvfi_rd_wdata  = trc_q.rd_wdata;
  assign xc_rvfi_pc_rdata  = trc_q.pc_rdata;
  assign xc_rvfi_pc_wdata  = trc_q.pc_wdata;
  assign xc_rvfi_mem_addr  = trc_q.mem_addr;
  assign xc_rvfi_mem_rmask = trc_q.mem_rmask;
  assign xc_rvfi_mem_wmask = trc_q.mem_wmask;
  assign xc_rvfi_mem_rdata = trc_q.mem_rdata;
  assign xc_rvfi_mem_wdata = trc_q.mem_wdata;

  logic counted;
  logic target;
  logic halt_hit;

`ifdef XCFI_TRIGGER_SKIP_TRAP_EN
  assign counted = rvfi_valid[0] & ~rvfi_trap[0];
`else
  assign counted = rvfi_valid[0];
`endif

  // A halting target still fires; only a non-target halt aborts.
  assign target   = counted & (retire_count == CNT_LAST);
  assign halt_hit = rvfi_valid[0] & rvfi_halt[0] & ~target;

  trig_state_e            state_q;
  trig_state_e            state_d;
  logic [CNT_W-1:0]       cnt_d;

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q      <= COUNT;
      retire_count <= '0;
    end else begin
      state_q      <= state_d;
      retire_count <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = retire_count;
    unique case (state_q)
      COUNT: begin
        if (target) begin
          state_d = FIRE;
          cnt_d   = CNT_FULL;
        end else if (halt_hit) begin
          state_d = HALT;
        end else if (counted) begin
          cnt_d   = retire_count + CNT_W'(1);
        end
      end
      FIRE:    state_d = DONE;
      DONE:    state_d = DONE;
      HALT:    state_d = HALT;
      default: state_d = COUNT;
    endcase
  end

  assign check        = (state_q == FIRE);
  assign done         = (state_q == DONE);
  assign halted_early = (state_q == HALT);

endmodule

// File: tb/tb_xcfi_check_trigger.sv
// Bench for xcfi_check_trigger: three instances at CHECK_DEPTH 2/3/4
// share one stimulus stream; trace is checked through a scoreboard.
module tb_xcfi_check_trigger;
  import xcfi_pkg::*;

  localparam int TW = $bits(trace_t);

  logic g_clk = 1'b0;
  logic g_resetn;
  trace_t in_t;

  trace_t [2:0]      xo;
  logic [2:0]        chk;
  logic [2:0]        dn;
  logic [2:0]        hl;
  logic [2:0][4:0]   cnt;

  int checks = 0;
  int errors = 0;

  trace_t expq[$];

  always #5 g_clk = ~g_clk;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    xcfi_check_trigger #(.CHECK_DEPTH(k + 2)) dut (
      .g_clk             (g_clk),
      .g_resetn          (g_resetn),
      .rvfi_valid        (in_t.valid),
      .rvfi_insn         (in_t.insn),
      .rvfi_trap         (in_t.trap),
      .rvfi_halt         (in_t.halt),
      .rvfi_intr         (in_t.intr),
      .rvfi_rs1_addr     (in_t.rs1_addr),
      .rvfi_rs2_addr     (in_t.rs2_addr),
      .rvfi_rs3_addr     (in_t.rs3_addr),
      .rvfi_rs1_rdata    (in_t.rs1_rdata),
      .rvfi_rs2_rdata    (in_t.rs2_rdata),
      .rvfi_rs3_rdata    (in_t.rs3_rdata),
      .rvfi_rd_addr      (in_t.rd_addr),
      .rvfi_rd_wdata     (in_t.rd_wdata),
      .rvfi_pc_rdata     (in_t.pc_rdata),
      .rvfi_pc_wdata     (in_t.pc_wdata),
      .rvfi_mem_addr     (in_t.mem_addr),
      .rvfi_mem_rmask    (in_t.mem_rmask),
      .rvfi_mem_wmask    (in_t.mem_wmask),
      .rvfi_mem_rdata    (in_t.mem_rdata),
      .rvfi_mem_wdata    (in_t.mem_wdata),
      .xc_rvfi_valid     (xo[k].valid),
      .xc_rvfi_insn      (xo[k].insn),
      .xc_rvfi_trap      (xo[k].trap),
      .xc_rvfi_halt      (xo[k].halt),
      .xc_rvfi_intr      (xo[k].intr),
      .xc_rvfi_rs1_addr  (xo[k].rs1_addr),
      .xc_rvfi_rs2_addr  (xo[k].rs2_addr),
      .xc_rvfi_rs3_addr  (xo[k].rs3_addr),
      .xc_rvfi_rs1_rdata (xo[k].rs1_rdata),
      .xc_rvfi_rs2_rdata (xo[k].rs2_rdata),
      .xc_rvfi_rs3_rdata (xo[k].rs3_rdata),
      .xc_rvfi_rd_addr   (xo[k].rd_addr),
      .xc_rvfi_rd_wdata  (xo[k].rd_wdata),
      .xc_rvfi_pc_rdata  (xo[k].pc_rdata),
      .xc_rvfi_pc_wdata  (xo[k].pc_wdata),
      .xc_rvfi_mem_addr  (xo[k].mem_addr),
      .xc_rvfi_mem_rmask (xo[k].mem_rmask),
      .xc_rvfi_mem_wmask (xo[k].mem_wmask),
      .xc_rvfi_mem_rdata (xo[k].mem_rdata),
      .xc_rvfi_mem_wdata (xo[k].mem_wdata),
      .check             (chk[k]),
      .retire_count      (cnt[k]),
      .done              (dn[k]),
      .halted_early      (hl[k])
    );
  end

  typedef struct {
    bit         rst;
    bit         v;
    bit         h;
    bit         t;
    logic [2:0] chk;
    logic [2:0] dn;
    logic [2:0] hl;
    logic [4:0] c2;
    logic [4:0] c3;
    logic [4:0] c4;
  } vec_t;

  vec_t tbl[$];

  task automatic cmp(input string n, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, got, exp);
    end
  endtask

  task automatic cmp_trace(input string n, input trace_t got,
                           input trace_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, got, exp);
    end
  endtask

  function automatic trace_t mkpkt(input bit v, input bit h, input bit t,
                                   input logic [31:0] pc);
    trace_t p;
    p.valid     = v;
    p.insn      = $urandom;
    p.trap      = t;
    p.halt      = h;
    p.intr      = 1'($urandom);
    p.rs1_addr  = 5'($urandom);
    p.rs2_addr  = 5'($urandom);
    p.rs3_addr  = 5'($urandom);
    p.rs1_rdata = $urandom;
    p.rs2_rdata = $urandom;
    p.rs3_rdata = $urandom;
    p.rd_addr   = 5'($urandom);
    p.rd_wdata  = $urandom;
    p.pc_rdata  = pc;
    p.pc_wdata  = $urandom;
    p.mem_addr  = $urandom;
    p.mem_rmask = 4'($urandom);
    p.mem_wmask = 4'($urandom);
    p.mem_rdata = $urandom;
    p.mem_wdata = $urandom;
    return p;
  endfunction

  task automatic sb_check();
    trace_t e;
    if (expq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_empty: got no expected entry, required one");
    end else begin
      e = expq.pop_front();
      for (int k = 0; k < 3; k++)
        cmp_trace($sformatf("trace[%0d]", k), xo[k], e);
    end
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input bit v, input bit h, input bit t,
                      input logic [31:0] pc);
    trace_t p;
    p = mkpkt(v, h, t, pc);
    in_t = p;
    expq.push_back(p);
    @(posedge g_clk);
    @(negedge g_clk);
    sb_check();
  endtask

  task automatic check_zero(input string n);
    cmp({n, "_check"}, 32'(chk), 32'd0);
    cmp({n, "_done"}, 32'(dn), 32'd0);
    cmp({n, "_halted"}, 32'(hl), 32'd0);
    cmp({n, "_count"}, 32'(cnt), 32'd0);
    for (int k = 0; k < 3; k++)
      cmp_trace($sformatf("%s_trace[%0d]", n, k), xo[k], '0);
  endtask

  task automatic do_reset();
    g_resetn = 1'b0;
    in_t = '0;
    #1;
    check_zero("reset");
    repeat (2) @(negedge g_clk);
    expq.delete();
    g_resetn = 1'b1;
  endtask

  initial begin
    trace_t p;
    int fires;
    g_resetn = 1'b0;
    in_t = '0;

    // rst v h t | check done halted | c2 c3 c4 ; bit0=D2 bit1=D3 bit2=D4
    tbl.push_back('{1,0,0,0, 3'b000,3'b000,3'b000, 0,0,0});
    tbl.push_back('{0,1,0,0, 3'b000,3'b000,3'b000, 1,1,1});
    tbl.push_back('{0,1,0,0, 3'b001,3'b000,3'b000, 2,2,2});
    tbl.push_back('{0,1,0,0, 3'b010,3'b001,3'b000, 2,3,3});
    tbl.push_back('{0,0,0,0, 3'b000,3'b011,3'b000, 2,3,3});
    tbl.push_back('{0,1,0,0, 3'b100,3'b011,3'b000, 2,3,4});
    tbl.push_back('{0,0,0,0, 3'b000,3'b111,3'b000, 2,3,4});
    tbl.push_back('{1,0,0,0, 3'b000,3'b000,3'b000, 0,0,0});
    tbl.push_back('{0,1,0,0, 3'b000,3'b000,3'b000, 1,1,1});
    tbl.push_back('{0,0,0,0, 3'b000,3'b000,3'b000, 1,1,1});
    tbl.push_back('{0,0,0,0, 3'b000,3'b000,3'b000, 1,1,1});
    tbl.push_back('{0,1,0,0, 3'b001,3'b000,3'b000, 2,2,2});
    tbl.push_back('{0,0,0,0, 3'b000,3'b001,3'b000, 2,2,2});
    tbl.push_back('{0,0,0,0, 3'b000,3'b001,3'b000, 2,2,2});
    tbl.push_back('{0,0,0,0, 3'b000,3'b001,3'b000, 2,2,2});
    tbl.push_back('{0,1,0,0, 3'b010,3'b001,3'b000, 2,3,3});
    tbl.push_back('{0,0,0,0, 3'b000,3'b011,3'b000, 2,3,3});
`ifdef XCFI_TRIGGER_SKIP_TRAP_EN
    tbl.push_back('{1,1,0,1, 3'b000,3'b000,3'b000, 0,0,0});
    tbl.push_back('{0,1,0,0, 3'b000,3'b000,3'b000, 1,1,1});
    tbl.push_back('{0,1,0,1, 3'b000,3'b000,3'b000, 1,1,1});
    tbl.push_back('{0,1,0,0, 3'b001,3'b000,3'b000, 2,2,2});
    tbl.push_back('{0,0,0,0, 3'b000,3'b001,3'b000, 2,2,2});
`else
    tbl.push_back('{1,1,0,1, 3'b000,3'b000,3'b000, 1,1,1});
    tbl.push_back('{0,1,0,0, 3'b001,3'b000,3'b000, 2,2,2});
    tbl.push_back('{0,1,0,1, 3'b010,3'b001,3'b000, 2,3,3});
    tbl.push_back('{0,1,0,0, 3'b100,3'b011,3'b000, 2,3,4});
    tbl.push_back('{0,0,0,0, 3'b000,3'b111,3'b000, 2,3,4});
`endif
    tbl.push_back('{1,1,0,0, 3'b000,3'b000,3'b000, 1,1,1});
    tbl.push_back('{0,1,1,0, 3'b001,3'b000,3'b110, 2,1,1});
    tbl.push_back('{0,1,0,0, 3'b000,3'b001,3'b110, 2,1,1});

    @(negedge g_clk);
    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      step(tbl[i].v, tbl[i].h, tbl[i].t, 32'h1000 + 32'(i * 4));
      cmp($sformatf("v%0d_check", i), 32'(chk), 32'(tbl[i].chk));
      cmp($sformatf("v%0d_done", i), 32'(dn), 32'(tbl[i].dn));
      cmp($sformatf("v%0d_halted", i), 32'(hl), 32'(tbl[i].hl));
      cmp($sformatf("v%0d_count", i), 32'(cnt),
          32'({tbl[i].c4, tbl[i].c3, tbl[i].c2}));
    end

    // Halted instance keeps ignoring retirements and never fires.
    fires = 0;
    for (int i = 0; i < 50; i++) begin
      step(1'b1, 1'($urandom), 1'b0, 32'h2000 + 32'(i * 4));
      if (chk[2] === 1'b1) fires++;
      cmp("halt_hold_count", 32'(cnt[2]), 32'd1);
      cmp("halt_hold_flag", 32'(hl[2]), 32'd1);
    end
    cmp("halt_no_check", 32'(fires), 32'd0);

    // Asynchronous reset in the middle of FIRE.
    do_reset();
    step(1'b1, 1'b0, 1'b0, 32'h3000);
    p = mkpkt(1'b1, 1'b0, 1'b0, 32'h3004);
    in_t = p;
    expq.push_back(p);
    @(posedge g_clk);
    #2;
    cmp("fire_before_reset", 32'(chk[0]), 32'd1);
    g_resetn = 1'b0;
    #1;
    check_zero("mid_fire");
    expq.delete();
    in_t = '0;
    @(negedge g_clk);
    g_resetn = 1'b1;
    step(1'b1, 1'b0, 1'b0, 32'h3008);
    cmp("refire_1_check", 32'(chk[0]), 32'd0);
    cmp("refire_1_count", 32'(cnt[0]), 32'd1);
    step(1'b1, 1'b0, 1'b0, 32'h300c);
    cmp("refire_2_check", 32'(chk[0]), 32'd1);
    cmp("refire_2_count", 32'(cnt[0]), 32'd2);
    step(1'b0, 1'b0, 1'b0, 32'h3010);
    cmp("refire_3_check", 32'(chk[0]), 32'd0);
    cmp("refire_3_done", 32'(dn[0]), 32'd1);

    // Random trace traffic through the register.
    for (int i = 0; i < 200; i++)
      step(1'($urandom), 1'($urandom), 1'($urandom), $urandom);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/xcfi_check_trigger.md
# xcfi_check_trigger

Formal-verification stage sitting directly upstream of the per-instruction checker. Registers the core's XCFI/RVFI trace bus by one cycle and counts retirements. Raises a single-cycle `check` strobe aligned with the registered trace of the CHECK_DEPTH-th counted retirement, so the checker evaluates exactly one instruction. Also reports whether the core halted before the target was reached.

## Interface
- XLEN, 32, data/address width.
- ILEN, 32, instruction width.
- NRET, 1, retire channels; only 1 supported, other values are an elaboration error.
- CHECK_DEPTH, 15, ordinal (1-based) of the counted retirement that fires `check`; range 1..2^CNT_W-1.
- CNT_W, 5, retire counter width.

Ports:
- g_clk  in  1  clock, all state on rising edge.
- g_resetn  in  1  reset, asynchronous, active-low.
- rvfi_*  in  full XCFI trace bus  core trace: valid, insn, trap, halt, intr, rs1/rs2/rs3 addr+rdata, rd addr+wdata, pc rdata/wdata, mem addr/rmask/wmask/rdata/wdata.
- xc_rvfi_*  out  same widths  registered trace, feeds the checker's trace inputs.
- check  out  1  one-cycle strobe qualifying the target retirement on `xc_rvfi_*`.
- retire_count  out  CNT_W  counted retirements so far, saturating at CHECK_DEPTH.
- done  out  1  target reached; sticky until reset.
- halted_early  out  1  halt retired before target; sticky until reset.

## Operation
- Trace register: every `xc_rvfi_*` field equals the corresponding `rvfi_*` field one cycle earlier. Data fields are captured unconditionally; `xc_rvfi_valid` follows `rvfi_valid`.
- Counted retirement: `rvfi_valid`=1, plus the Configuration qualifier.
- FSM states are COUNT, FIRE, DONE and HALT.
  - COUNT (reset state):
    - A counted retirement with `retire_count`=CHECK_DEPTH-1 goes to FIRE.
    - Otherwise a counted retirement increments `retire_count`.
    - A valid retirement with `rvfi_halt`=1 that is not the target goes to HALT. This check takes priority over increment.
  - FIRE: lasts exactly one cycle. `check`=1 and `retire_count`=CHECK_DEPTH. Always moves to DONE.
  - DONE: `done`=1. Counter is frozen, further retirements are ignored, `check`=0.
  - HALT: `halted_early`=1, `check` is never raised. Terminal until reset.
- Target retirement that also has `halt`=1 goes to FIRE, not HALT. The checker still sees it.
- Back-to-back valid retirements on consecutive cycles are each counted; there are no bubbles.
- `rvfi_valid`=0 leaves all state unchanged.
- CHECK_DEPTH=1: the first counted retirement fires.

## Timing
- Latency is 1 cycle: the input trace at edge N appears on `xc_rvfi_*` after edge N.
- `check` is high in the same cycle `xc_rvfi_valid`=1 for the target instruction. It is high for exactly one cycle per reset epoch.
- `done` rises the cycle after `check`.
- `halted_early` rises one cycle after the halting retirement is sampled, i.e. aligned with `xc_rvfi_halt`.
- Reset values:
  - all `xc_rvfi_*` = 0
  - `check` = 0
  - `retire_count` = 0
  - `done` = 0
  - `halted_early` = 0
  - FSM = COUNT
- Asynchronous reset assertion mid-operation (including during FIRE) clears everything immediately. The first retirement after release counts as 1.

## Configuration
- `XCFI_TRIGGER_SKIP_TRAP_EN` defined: retirements with `rvfi_trap`=1 are not counted and cannot be the target; they still pass through the trace register. A trapping retirement with `halt`=1 in COUNT still goes to HALT.
- Not defined: every valid retirement counts, trapping or not.

## Structure
- Shared package `xcfi_pkg` holds:
  - the FSM state enum (COUNT/FIRE/DONE/HALT);
  - the trace packet struct typedef, parameterised widths via XLEN/ILEN constants;
  - the default CHECK_DEPTH constant.
- One sub-module, `xcfi_trace_reg`: the pure asynchronous-reset pipeline register for the trace packet. The FSM and counter live in the top.

## Test plan
- CHECK_DEPTH=3; valid retirements at cycles 2,3,4 → `check`=1 only in cycle 5 with `xc_rvfi_pc_rdata` equal to the third PC; `done`=1 from cycle 6; `retire_count`=3.
- CHECK_DEPTH=3; valids at cycles 2,5,9 separated by `valid`=0 → count steps 1,2 and holds; `check` only in cycle 10.
- CHECK_DEPTH=4; second retirement has `halt`=1 → `halted_early`=1 next cycle, `check` never asserted for 50 cycles, `retire_count`=1.
- With `XCFI_TRIGGER_SKIP_TRAP_EN` defined, CHECK_DEPTH=2; retirements trap,ok,trap,ok → `check` aligned with the fourth retirement. Without the macro, `check` is aligned with the second.
- CHECK_DEPTH=2; `g_resetn` dropped during FIRE → `check` falls immediately, all outputs 0. After release, two more retirements refire `check` once.
- Random trace fields on every cycle → `xc_rvfi_*` equals the previous-cycle `rvfi_*` bit-exactly, including the mem masks and rs3 fields.
